// File: rtl/dmem_responder.sv
// dmem_responder: word RAM with byte-lane stores, registered loads, tohost MMIO and access counters.
// A store and a load to the same word in one cycle return the merged post-store word.
module dmem_responder #(
   parameter int          AW          = 10,
   parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             c_rst_n,
   input  logic             c_dmem_load,
   input  logic [31:0]      dmem_load_addr,
   output logic [31:0]      dmem_load_data,
   input  logic             c_dmem_store,
   input  logic [31:0]      dmem_store_addr,
   input  logic [1:0]       dmem_store_width,
   input  logic [31:0]      dmem_store_data,
   output logic             done,
   output logic [31:0]      done_code,
   output logic             c_access_err,
   output logic [CNT_W-1:0] load_count,
   output logic [CNT_W-1:0] store_count
);
   localparam logic [31:0] RAM_END = 32'(4 << AW);
   logic [31:0] mem [2**AW];
   logic        st_ram, st_host, st_bad_align, st_ok, st_err, st_same;
   logic        ld_ram, ld_host, ld_ok, ld_err;
   logic [3:0]  be;
   logic [31:0] wdata, rword, merged;
   always_comb begin
      st_ram       = dmem_store_addr < RAM_END;
      st_host      = dmem_store_addr[31:2] == TOHOST_ADDR[31:2];
      st_bad_align = dmem_store_width == 2'd3 ||
                     (dmem_store_width == 2'd1 && dmem_store_addr[0]) ||
                     (dmem_store_width == 2'd2 && dmem_store_addr[1:0] != 2'd0);
      st_ok        = c_dmem_store && !st_bad_align && (st_ram || (st_host && dmem_store_width == 2'd2));
      st_err       = c_dmem_store && !st_ok;
      ld_ram       = dmem_load_addr < RAM_END;
      ld_host      = dmem_load_addr[31:2] == TOHOST_ADDR[31:2];
      ld_ok        = c_dmem_load && (ld_ram || ld_host);
      ld_err       = c_dmem_load && !ld_ok;
      be           = dmem_store_width == 2'd0 ? 4'b0001 << dmem_store_addr[1:0] :
                     dmem_store_width == 2'd1 ? (dmem_store_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata        = dmem_store_width == 2'd0 ? {4{dmem_store_data[7:0]}} :
                     dmem_store_width == 2'd1 ? {2{dmem_store_data[15:0]}} : dmem_store_data;
      st_same      = st_ok && dmem_store_addr[31:2] == dmem_load_addr[31:2];
      rword        = ld_host ? done_code : mem[dmem_load_addr[AW+1:2]];
      // write-first bypass: lanes being stored this cycle override the old word
      for (int i = 0; i < 4; i++)
         merged[8*i +: 8] = st_same && be[i] ? wdata[8*i +: 8] : rword[8*i +: 8];
   end
   always_ff @(posedge clk)
      if (c_rst_n && st_ok && st_ram)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[dmem_store_addr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
   always_ff @(posedge clk)
      if (!c_rst_n) begin
         dmem_load_data <= '0;
         done           <= 1'b0;
         done_code      <= '0;
         c_access_err   <= 1'b0;
         load_count     <= '0;
         store_count    <= '0;
      end else begin
         if (c_dmem_load) dmem_load_data <= ld_ok ? merged : '0;
         if (st_ok && st_host) begin
            done_code <= dmem_store_data;
            if (|dmem_store_data) done <= 1'b1;
         end
         c_access_err <= ld_err || st_err;
         if (ld_ok && !(&load_count)) load_count <= load_count + 1'b1;
         if (st_ok && !(&store_count)) store_count <= store_count + 1'b1;
      end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven directed vectors plus a counter-saturation sequence.
module tb_dmem_responder;
   logic        clk = 1'b0;
   logic        c_rst_n, c_dmem_load, c_dmem_store;
   logic [31:0] dmem_load_addr, dmem_store_addr, dmem_store_data;
   logic [1:0]  dmem_store_width;
   logic [31:0] dmem_load_data, done_code;
   logic        done, c_access_err;
   logic [15:0] load_count, store_count;
   int          errors = 0;
   int          checks = 0;

   dmem_responder dut (
      .clk(clk), .c_rst_n(c_rst_n),
      .c_dmem_load(c_dmem_load), .dmem_load_addr(dmem_load_addr), .dmem_load_data(dmem_load_data),
      .c_dmem_store(c_dmem_store), .dmem_store_addr(dmem_store_addr),
      .dmem_store_width(dmem_store_width), .dmem_store_data(dmem_store_data),
      .done(done), .done_code(done_code), .c_access_err(c_access_err),
      .load_count(load_count), .store_count(store_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rn;
      logic        ld;
      logic [31:0] la;
      logic        st;
      logic [31:0] sa;
      logic [1:0]  sw;
      logic [31:0] sd;
      logic [31:0] e_ld;
      logic        e_err;
      logic        e_done;
      logic [31:0] e_code;
      int          e_lc;
      int          e_sc;
   } vec_t;

   vec_t vecs[25];

   function automatic vec_t mk(logic rn, logic ld, logic [31:0] la, logic st, logic [31:0] sa,
                               logic [1:0] sw, logic [31:0] sd, logic [31:0] e_ld, logic e_err,
                               logic e_done, logic [31:0] e_code, int e_lc, int e_sc);
      vec_t v;
      v.rn = rn; v.ld = ld; v.la = la; v.st = st; v.sa = sa; v.sw = sw; v.sd = sd;
      v.e_ld = e_ld; v.e_err = e_err; v.e_done = e_done; v.e_code = e_code;
      v.e_lc = e_lc; v.e_sc = e_sc;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input vec_t v);
      chk("load_data", idx, dmem_load_data, v.e_ld);
      chk("access_err", idx, {31'b0, c_access_err}, {31'b0, v.e_err});
      chk("done", idx, {31'b0, done}, {31'b0, v.e_done});
      chk("done_code", idx, done_code, v.e_code);
      chk("load_count", idx, {16'b0, load_count}, 32'(v.e_lc));
      chk("store_count", idx, {16'b0, store_count}, 32'(v.e_sc));
   endtask

   task automatic drive(input vec_t v);
      c_rst_n = v.rn; c_dmem_load = v.ld; dmem_load_addr = v.la;
      c_dmem_store = v.st; dmem_store_addr = v.sa; dmem_store_width = v.sw; dmem_store_data = v.sd;
   endtask

   initial begin
      //            rn ld  la            st  sa            sw    sd             e_ld          err done code          lc  sc
      vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,        2'd0, 32'h0,        32'h0,        0, 0, 32'h0,        0,  0);
      vecs[1]  = mk(1, 0, 32'h0,        1, 32'h10,       2'd2, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0,        0,  1);
      vecs[2]  = mk(1, 1, 32'h10,       0, 32'h0,        2'd0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0,        1,  1);
      vecs[3]  = mk(1, 0, 32'h0,        1, 32'h10,       2'd2, 32'h11223344, 32'hDEADBEEF, 0, 0, 32'h0,        1,  2);
      vecs[4]  = mk(1, 0, 32'h0,        1, 32'h13,       2'd0, 32'h000000AA, 32'hDEADBEEF, 0, 0, 32'h0,        1,  3);
      vecs[5]  = mk(1, 0, 32'h0,        1, 32'h10,       2'd1, 32'h00005566, 32'hDEADBEEF, 0, 0, 32'h0,        1,  4);
      vecs[6]  = mk(1, 1, 32'h12,       0, 32'h0,        2'd0, 32'h0,        32'hAA225566, 0, 0, 32'h0,        2,  4);
      vecs[7]  = mk(1, 0, 32'h0,        1, 32'h11,       2'd1, 32'hFFFFFFFF, 32'hAA225566, 1, 0, 32'h0,        2,  4);
      vecs[8]  = mk(1, 0, 32'h0,        1, 32'h12,       2'd2, 32'hFFFFFFFF, 32'hAA225566, 1, 0, 32'h0,        2,  4);
      vecs[9]  = mk(1, 0, 32'h0,        1, 32'h10,       2'd3, 32'hFFFFFFFF, 32'hAA225566, 1, 0, 32'h0,        2,  4);
      vecs[10] = mk(1, 1, 32'h10,       0, 32'h0,        2'd0, 32'h0,        32'hAA225566, 0, 0, 32'h0,        3,  4);
      vecs[11] = mk(1, 0, 32'h0,        1, 32'h20,       2'd2, 32'h0,        32'hAA225566, 0, 0, 32'h0,        3,  5);
      vecs[12] = mk(1, 1, 32'h20,       1, 32'h20,       2'd2, 32'h12345678, 32'h12345678, 0, 0, 32'h0,        4,  6);
      vecs[13] = mk(1, 0, 32'h0,        1, 32'h1000,     2'd2, 32'h0,        32'h12345678, 0, 0, 32'h0,        4,  7);
      vecs[14] = mk(1, 0, 32'h0,        1, 32'h1000,     2'd2, 32'h1,        32'h12345678, 0, 1, 32'h1,        4,  8);
      vecs[15] = mk(1, 0, 32'h0,        1, 32'h1000,     2'd0, 32'h7,        32'h12345678, 1, 1, 32'h1,        4,  8);
      vecs[16] = mk(1, 1, 32'h1000,     0, 32'h0,        2'd0, 32'h0,        32'h1,        0, 1, 32'h1,        5,  8);
      vecs[17] = mk(1, 1, 32'h1003,     1, 32'h1000,     2'd2, 32'h5,        32'h5,        0, 1, 32'h5,        6,  9);
      vecs[18] = mk(1, 1, 32'h10000000, 0, 32'h0,        2'd0, 32'h0,        32'h0,        1, 1, 32'h5,        6,  9);
      vecs[19] = mk(1, 0, 32'h0,        1, 32'h1004,     2'd2, 32'h9,        32'h0,        1, 1, 32'h5,        6,  9);
      vecs[20] = mk(1, 0, 32'h0,        1, 32'h1000,     2'd2, 32'h0,        32'h0,        0, 1, 32'h0,        6,  10);
      vecs[21] = mk(1, 1, 32'h10,       1, 32'h24,       2'd2, 32'hCAFEF00D, 32'hAA225566, 0, 1, 32'h0,        7,  11);
      vecs[22] = mk(1, 1, 32'h24,       0, 32'h0,        2'd0, 32'h0,        32'hCAFEF00D, 0, 1, 32'h0,        8,  11);
      vecs[23] = mk(0, 1, 32'h10,       1, 32'h10,       2'd2, 32'hFFFFFFFF, 32'h0,        0, 0, 32'h0,        0,  0);
      vecs[24] = mk(1, 1, 32'h10,       0, 32'h0,        2'd0, 32'h0,        32'hAA225566, 0, 0, 32'h0,        1,  0);
      drive(vecs[0]);
      @(negedge clk);
      for (int i = 0; i < 25; i++) begin
         drive(vecs[i]);
         @(negedge clk);
         chk_all(i, vecs[i]);
      end
      // both counters must stick at all-ones rather than wrap
      c_rst_n = 1'b1; c_dmem_load = 1'b1; dmem_load_addr = 32'h10;
      c_dmem_store = 1'b1; dmem_store_addr = 32'h40; dmem_store_width = 2'd2; dmem_store_data = 32'h0;
      repeat (65540) @(negedge clk);
      chk("load_count_sat", 100, {16'b0, load_count}, 32'hFFFF);
      chk("store_count_sat", 100, {16'b0, store_count}, 32'hFFFF);
      chk("sat_load_data", 100, dmem_load_data, 32'hAA225566);
      chk("sat_access_err", 100, {31'b0, c_access_err}, 32'h0);
      c_dmem_load = 1'b0; c_dmem_store = 1'b0;
      @(negedge clk);
      chk("load_count_hold", 101, {16'b0, load_count}, 32'hFFFF);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
